// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter
//
// Shares one single-port synchronous RAM between two requesters that use the
// start/ready/done handshake. A request is accepted only while the arbiter is
// idle. The winning command is latched and driven onto the RAM port for one
// cycle. For reads the block then waits out the RAM read latency and captures
// the data. A one-cycle done pulse goes back to the owner.
//
// Build option:
//   ARB_ROUND_ROBIN_EN  When defined, a tie goes to the requester that did not
//                       win the last grant. Otherwise requester 0 always wins
//                       a tie.
//
// Parameters:
//   AW       RAM address width
//   DW       RAM data width
//   RAM_LAT  cycles from the ram_en cycle to valid ram_rdata (1..4)
//
// Ports:
//   clk, rst             clock; asynchronous active-low reset
//   reqN_start           level request, held until accepted
//   reqN_we              1 = write, 0 = read
//   reqN_addr/wdata      command address and write data
//   reqN_ready           arbiter idle; a start is accepted this cycle
//   reqN_done            one-cycle completion pulse for requester N
//   reqN_rdata           last read result for requester N
//   ram_en/we/addr/wdata RAM command port (registered)
//   ram_rdata            RAM read data

module ram_access_arbiter #(
    parameter int unsigned AW      = 8,
    parameter int unsigned DW      = 16,
    parameter int unsigned RAM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          req0_start,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          req0_ready,
    output logic          req0_done,
    output logic [DW-1:0] req0_rdata,

    input  logic          req1_start,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          req1_ready,
    output logic          req1_done,
    output logic [DW-1:0] req1_rdata,

    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } state_t;

    state_t     state_q;
    logic       owner_q;
    logic       cmd_we_q;
    logic [2:0] cnt_q;

    logic any_start;
    logic grant1;

    assign any_start = req0_start | req1_start;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_q;

    // On a tie, requester 1 wins only if requester 0 took the previous grant.
    assign grant1 = req1_start & (~req0_start | ~last_grant_q);
`else
    assign grant1 = req1_start & ~req0_start;
`endif

    assign req0_ready = (state_q == StIdle);
    assign req1_ready = (state_q == StIdle);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            owner_q    <= 1'b0;
            cmd_we_q   <= 1'b0;
            cnt_q      <= 3'd0;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;
            req0_rdata <= '0;
            req1_rdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            // Strobes and done pulses last a single cycle unless set below.
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            req0_done <= 1'b0;
            req1_done <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (any_start) begin
                        // ram_addr/ram_wdata double as the latched command.
                        owner_q   <= grant1;
                        cmd_we_q  <= grant1 ? req1_we : req0_we;
                        ram_addr  <= grant1 ? req1_addr : req0_addr;
                        ram_wdata <= grant1 ? req1_wdata : req0_wdata;
                        ram_en    <= 1'b1;
                        ram_we    <= grant1 ? req1_we : req0_we;
                        state_q   <= StIssue;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant_q <= grant1;
`endif
                    end
                end

                StIssue: begin
                    if (cmd_we_q) begin
                        req0_done <= ~owner_q;
                        req1_done <= owner_q;
                        state_q   <= StDone;
                    end else begin
                        cnt_q   <= 3'(RAM_LAT - 1);
                        state_q <= StWait;
                    end
                end

                StWait: begin
                    if (cnt_q == 3'd0) begin
                        if (owner_q) begin
                            req1_rdata <= ram_rdata;
                        end else begin
                            req0_rdata <= ram_rdata;
                        end
                        req0_done <= ~owner_q;
                        req1_done <= owner_q;
                        state_q   <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end

                StDone: begin
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
